pio_in_capture: RTL and testbench

Parametrised Avalon-MM input PIO slave for the SOPC system. Generalises the single-bit input port to WIDTH bits. Adds optional input synchronisation, per-bit edge capture with write-1-to-clear, an interrupt mask and a registered interrupt request. Sits between board-level status inputs (end-of-stroke switches, actuator feedback) and the Nios II data master.

---
 rtl/pio_in_pkg.sv | 22 ++
 rtl/pio_in_sync_edge.sv | 47 ++++
 rtl/pio_in_capture.sv | 84 ++++++++
 tb/tb_pio_in_capture.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pio_in_pkg.sv
// Shared constants for the parametrised input PIO.
// Define PIO_IN_SYNC_EN to get a two-flop synchroniser (depth 2) instead of a single input register.
package pio_in_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    localparam int IRQ_LEVEL = 0;
    localparam int IRQ_EDGE  = 1;

`ifdef PIO_IN_SYNC_EN
    localparam int SYNC_DEPTH = 2;
`else
    localparam int SYNC_DEPTH = 1;
`endif

endpackage

// File: rtl/pio_in_sync_edge.sv
// Per-bit input pipeline (depth SYNC_DEPTH), one-cycle delayed copy and edge event detection.
// Pipeline depth follows PIO_IN_SYNC_EN through pio_in_pkg::SYNC_DEPTH.
module pio_in_sync_edge
    import pio_in_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int EDGE_TYPE = EDGE_RISING
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] evt
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [SYNC_DEPTH-1:0] pipe_reg;
            logic                  prev_reg;
            logic                  s_bit;

            // New samples enter at bit 0; the oldest stage is the synchronised value.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    pipe_reg <= '0;
                    prev_reg <= 1'b0;
                end else begin
                    pipe_reg <= (pipe_reg << 1) | SYNC_DEPTH'(in_port[gi]);
                    prev_reg <= s_bit;
                end
            end

            assign s_bit = pipe_reg[SYNC_DEPTH-1];
            assign s[gi] = s_bit;

            if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
                assign evt[gi] = ~s_bit & prev_reg;
            end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
                assign evt[gi] = s_bit ^ prev_reg;
            end else begin : g_rise
                assign evt[gi] = s_bit & ~prev_reg;
            end
        end
    endgenerate

endmodule

// File: rtl/pio_in_capture.sv
// Avalon-MM input PIO slave: data readback, edge capture with write-1-to-clear, irq mask and registered irq.
// Input synchronisation depth is selected by PIO_IN_SYNC_EN (see pio_in_pkg).
module pio_in_capture
    import pio_in_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int EDGE_TYPE = EDGE_RISING,
    parameter int IRQ_MODE  = IRQ_EDGE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] evt;
    logic [WIDTH-1:0] irqmask_reg;
    logic [WIDTH-1:0] edgecap_reg;
    logic [WIDTH-1:0] edgecap_next;
    logic [WIDTH-1:0] clr;
    logic [31:0]      rd_next;
    logic             irq_next;
    logic             wr;
    logic             unused_wdata;

    pio_in_sync_edge #(
        .WIDTH     (WIDTH),
        .EDGE_TYPE (EDGE_TYPE)
    ) u_sync_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .in_port (in_port),
        .s       (s),
        .evt     (evt)
    );

    assign wr           = chipselect & ~write_n;
    assign unused_wdata = ^writedata;

    always_comb begin
        clr = '0;
        if (wr && (address == ADDR_EDGECAP)) begin
            clr = writedata[WIDTH-1:0];
        end
        // A fresh event wins over a clear arriving in the same cycle.
        edgecap_next = evt | (edgecap_reg & ~clr);

        rd_next = '0;
        case (address)
            ADDR_DATA:    rd_next[WIDTH-1:0] = s;
            ADDR_IRQMASK: rd_next[WIDTH-1:0] = irqmask_reg;
            ADDR_EDGECAP: rd_next[WIDTH-1:0] = edgecap_reg;
            default:      rd_next = '0;
        endcase

        case (IRQ_MODE)
            IRQ_LEVEL: irq_next = |(s & irqmask_reg);
            default:   irq_next = |(edgecap_reg & irqmask_reg);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irqmask_reg <= '0;
            edgecap_reg <= '0;
            readdata    <= '0;
            irq         <= 1'b0;
        end else begin
            edgecap_reg <= edgecap_next;
            if (wr && (address == ADDR_IRQMASK)) begin
                irqmask_reg <= writedata[WIDTH-1:0];
            end
            readdata <= rd_next;
            irq      <= irq_next;
        end
    end

endmodule

// File: tb/tb_pio_in_capture.sv
// Testbench for pio_in_capture: a rising/edge-irq instance and a falling/level-irq instance
// share the bus and inputs and are checked every cycle against a sample-history model.
module tb_pio_in_capture;
    import pio_in_pkg::*;

    localparam int D = SYNC_DEPTH;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] rd_a, rd_b;
    logic        irq_a, irq_b;

    always #5 clk = ~clk;

    pio_in_capture #(.WIDTH(8), .EDGE_TYPE(EDGE_RISING), .IRQ_MODE(IRQ_EDGE)) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_a), .irq(irq_a)
    );

    pio_in_capture #(.WIDTH(8), .EDGE_TYPE(EDGE_FALLING), .IRQ_MODE(IRQ_LEVEL)) dut_b (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_b), .irq(irq_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: hist[k] is the in_port value sampled k edges ago (hist[0] newest).
    logic [7:0]  hist[$];
    logic [7:0]  m_mask, m_cap_a, m_cap_b;
    logic [31:0] m_rd_a, m_rd_b;
    logic        m_irq_a, m_irq_b;

    function automatic logic [31:0] reg_read(logic [1:0] a, logic [7:0] sv, logic [7:0] mk, logic [7:0] cp);
        case (a)
            2'd0:    return {24'b0, sv};
            2'd2:    return {24'b0, mk};
            2'd3:    return {24'b0, cp};
            default: return 32'b0;
        endcase
    endfunction

    task automatic model_clear();
        hist = {};
        for (int k = 0; k <= D; k++) hist.push_back(8'h00);
        m_mask = 0; m_cap_a = 0; m_cap_b = 0;
        m_rd_a = 0; m_rd_b = 0; m_irq_a = 0; m_irq_b = 0;
    endtask

    // Advance the model across one clock edge using the inputs currently driven.
    task automatic model_step();
        logic [7:0] s_v, p_v, clr;
        logic       wr;
        if (!reset_n) begin
            model_clear();
            return;
        end
        s_v = hist[D-1];
        p_v = hist[D];
        wr  = chipselect && !write_n;
        clr = (wr && address == 2'd3) ? writedata[7:0] : 8'h00;
        m_rd_a  = reg_read(address, s_v, m_mask, m_cap_a);
        m_rd_b  = reg_read(address, s_v, m_mask, m_cap_b);
        m_irq_a = |(m_cap_a & m_mask);
        m_irq_b = |(s_v & m_mask);
        m_cap_a = (s_v & ~p_v) | (m_cap_a & ~clr);
        m_cap_b = (~s_v & p_v) | (m_cap_b & ~clr);
        if (wr && address == 2'd2) m_mask = writedata[7:0];
        hist.push_front(in_port);
        void'(hist.pop_back());
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("rd_a", rd_a, m_rd_a);
        chk("irq_a", {31'b0, irq_a}, {31'b0, m_irq_a});
        chk("rd_b", rd_b, m_rd_b);
        chk("irq_b", {31'b0, irq_b}, {31'b0, m_irq_b});
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic wr_reg(logic [1:0] a, logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        cycle();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; address = 2'd2; chipselect = 1'b1; write_n = 1'b0;
        writedata = 32'hFF; in_port = 8'hFF;
        model_clear();
        @(negedge clk);

        // Reset with inputs high and a write pending: everything stays zero.
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("rst_rd", rd_a, 32'h0);
            chk("rst_irq", {31'b0, irq_a}, 32'h0);
        end
        chipselect = 1'b0; write_n = 1'b1;
        reset_n = 1'b1;
        idle(2);
        chk("rst_mask_discarded", rd_a, 32'h0);
        address = 2'd3;
        idle(D + 3);
        chk("rst_release_edge", rd_a, 32'hFF);
        chk("rst_release_no_fall", rd_b, 32'h0);
        wr_reg(2'd3, 32'hFF);

        // Data path latency.
        address = 2'd0; in_port = 8'h00;
        idle(D + 3);
        in_port = 8'hA5;
        for (int j = 1; j <= D + 1; j++) begin
            cycle();
            if (j <= D) chk("data_early", rd_a, 32'h0);
            else        chk("data_valid", rd_a, 32'hA5);
        end

        // Edge irq and clear.
        in_port = 8'h00;
        idle(D + 2);
        wr_reg(2'd2, 32'h01);
        wr_reg(2'd3, 32'hFF);
        idle(2);
        chk("edge_irq_idle", {31'b0, irq_a}, 32'h0);
        in_port = 8'h01;
        for (int j = 1; j <= D + 2; j++) begin
            cycle();
            if (j == D + 1) chk("edge_irq_early", {31'b0, irq_a}, 32'h0);
            if (j == D + 2) chk("edge_irq_set", {31'b0, irq_a}, 32'h1);
        end
        wr_reg(2'd3, 32'h01);
        chk("edge_irq_hold", {31'b0, irq_a}, 32'h1);
        cycle();
        chk("edge_irq_cleared", {31'b0, irq_a}, 32'h0);

        // Masking.
        wr_reg(2'd2, 32'h00);
        in_port = 8'h00;
        idle(D + 2);
        wr_reg(2'd3, 32'hFF);
        in_port = 8'hFF; address = 2'd3;
        for (int j = 0; j < D + 3; j++) begin
            cycle();
            chk("mask_irq_low", {31'b0, irq_a}, 32'h0);
        end
        chk("mask_cap_all", rd_a, 32'hFF);
        wr_reg(2'd2, 32'h80);
        chk("mask_irq_delay", {31'b0, irq_a}, 32'h0);
        cycle();
        chk("mask_irq_set", {31'b0, irq_a}, 32'h1);

        // Event and clear in the same cycle.
        in_port = 8'h00;
        idle(D + 3);
        wr_reg(2'd3, 32'hFF);
        cycle();
        in_port = 8'h04;
        idle(D);
        wr_reg(2'd3, 32'h04);
        cycle();
        chk("simul_keep", rd_a, 32'h04);
        wr_reg(2'd3, 32'h04);
        cycle();
        chk("simul_second_clear", rd_a, 32'h0);

        // Falling capture and level irq on dut_b.
        wr_reg(2'd2, 32'h01);
        in_port = 8'h01;
        idle(D + 3);
        wr_reg(2'd3, 32'hFF);
        cycle();
        in_port = 8'h00;
        idle(2);
        in_port = 8'h01;
        address = 2'd3;
        idle(D + 3);
        chk("fall_cap", rd_b, 32'h01);
        chk("level_irq_high", {31'b0, irq_b}, 32'h1);
        in_port = 8'h00;
        for (int j = 1; j <= D + 1; j++) begin
            cycle();
            if (j == D)     chk("level_irq_hold", {31'b0, irq_b}, 32'h1);
            if (j == D + 1) chk("level_irq_low", {31'b0, irq_b}, 32'h0);
        end

        // Randomised traffic against the model.
        for (int k = 0; k < 500; k++) begin
            in_port = 8'($urandom);
            address = 2'($urandom);
            writedata = $urandom;
            if ($urandom_range(0, 99) < 30) begin
                chipselect = 1'b1; write_n = 1'b0;
            end else begin
                chipselect = 1'($urandom); write_n = 1'b1;
            end
            reset_n = ($urandom_range(0, 199) != 0);
            cycle();
        end
        reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1;
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
